// File: rtl/enc_limit_monitor.sv
// enc_limit_monitor: per-channel encoder position window check with persistence filter,
// latched fault and registered amplifier-disable request.
module enc_limit_monitor #(
  parameter int NUM_CH = 4,
  parameter int PERSIST = 16,
  parameter int CNT_W = 8,
  parameter logic [3:0] ADDR_MAIN = 4'h1
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [24:0]       enc_data1,
  input  logic [24:0]       enc_data2,
  input  logic [24:0]       enc_data3,
  input  logic [24:0]       enc_data4,
  input  logic [15:0]       reg_waddr,
  input  logic [31:0]       reg_wdata,
  input  logic              reg_wen,
  input  logic [3:0]        reg_raddr_chan,
  output logic [31:0]       reg_lim_data,
  output logic [NUM_CH-1:0] lim_fault,
  output logic              amp_disable_req
);
  localparam logic [3:0] OFF_LIM_LO = 4'hD;
  localparam logic [3:0] OFF_LIM_HI = 4'hE;
  localparam logic [3:0] OFF_LIM_CTRL = 4'hF;
  localparam logic [CNT_W-1:0] P_MAX = CNT_W'(PERSIST);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  typedef enum logic [1:0] {IDLE, ARMED, PENDING, FAULT} state_t;
  logic [24:0] enc [NUM_CH];
  logic [23:0] lo_a [NUM_CH];
  logic [23:0] hi_a [NUM_CH];
  logic [1:0] st_a [NUM_CH];
  logic [NUM_CH-1:0] en_a, oe_a;
  logic wr_main;
  logic unused;
  assign enc[0] = enc_data1;
  assign enc[1] = enc_data2;
  assign enc[2] = enc_data3;
  assign enc[3] = enc_data4;
  assign wr_main = reg_wen && reg_waddr[15:12] == ADDR_MAIN;
  assign unused = ^{reg_waddr[11:8], reg_wdata[30:24]};
  for (genvar g = 0; g < NUM_CH; g++) begin : ch
    logic sel, wr_lo, wr_hi, wr_ctrl, viol;
    logic [23:0] lo, hi;
    logic en, oe;
    logic [CNT_W-1:0] cnt;
    state_t st;
    assign sel = wr_main && reg_waddr[7:4] == 4'(g + 1);
    assign wr_lo = sel && reg_waddr[3:0] == OFF_LIM_LO;
    assign wr_hi = sel && reg_waddr[3:0] == OFF_LIM_HI;
    assign wr_ctrl = sel && reg_waddr[3:0] == OFF_LIM_CTRL;
    // lo > hi makes every position violate, which is kept as a deliberate test hook
    assign viol = enc[g][23:0] < lo || enc[g][23:0] > hi || (oe && enc[g][24]);
    always_ff @(posedge sysclk or negedge reset)
      if (!reset) begin
        lo <= 24'h000000;
        hi <= 24'hFFFFFF;
        en <= 1'b0;
        oe <= 1'b0;
        cnt <= '0;
        st <= IDLE;
      end else begin
        if (wr_lo) lo <= reg_wdata[23:0];
        if (wr_hi) hi <= reg_wdata[23:0];
        if (wr_ctrl) begin
          en <= reg_wdata[0];
          oe <= reg_wdata[1];
        end
        case (st)
          IDLE: begin
            cnt <= '0;
            if (en) st <= ARMED;
          end
          ARMED:
            if (!en) st <= IDLE;
            else if (viol) begin
              st <= PERSIST == 1 ? FAULT : PENDING;
              cnt <= ONE;
            end
          PENDING:
            if (!en) begin
              st <= IDLE;
              cnt <= '0;
            end else if (!viol) begin
              st <= ARMED;
              cnt <= '0;
            end else begin
              cnt <= cnt + ONE == P_MAX ? P_MAX : cnt + ONE;
              if (cnt + ONE == P_MAX) st <= FAULT;
            end
          default:
            // only an explicit clear leaves FAULT; a pending violation is re-filtered from scratch
            if (wr_ctrl && reg_wdata[31]) begin
              st <= reg_wdata[0] ? ARMED : IDLE;
              cnt <= '0;
            end
        endcase
      end
    assign lim_fault[g] = st == FAULT;
    assign lo_a[g] = lo;
    assign hi_a[g] = hi;
    assign st_a[g] = st;
    assign en_a[g] = en;
    assign oe_a[g] = oe;
  end
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) amp_disable_req <= 1'b0;
    else amp_disable_req <= |lim_fault;
  always_comb begin
    reg_lim_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (reg_raddr_chan[2:0] == 3'(i + 1))
        reg_lim_data = {st_a[i], oe_a[i], en_a[i], 3'b000, lim_fault[i],
                        reg_raddr_chan[3] ? hi_a[i] : lo_a[i]};
  end
endmodule

// File: tb/tb_enc_limit_monitor.sv
// tb_enc_limit_monitor: directed and randomized checks against a run-length reference model.
module tb_enc_limit_monitor;
  localparam int P = 16;
  localparam logic [3:0] AM = 4'h1;
  logic sysclk = 1'b0, reset = 1'b0;
  logic [24:0] enc [4];
  logic [15:0] reg_waddr = '0;
  logic [31:0] reg_wdata = '0;
  logic reg_wen = 1'b0;
  logic [3:0] reg_raddr_chan = '0;
  logic [31:0] reg_lim_data;
  logic [3:0] lim_fault;
  logic amp_disable_req;
  int checks = 0, failures = 0;
  logic [23:0] m_lo [4], m_hi [4];
  bit m_en [4], m_oe [4], m_act [4], m_flt [4];
  int m_run [4];
  bit m_amp;

  enc_limit_monitor #(.NUM_CH(4), .PERSIST(P), .CNT_W(8), .ADDR_MAIN(AM)) dut (
    .sysclk(sysclk), .reset(reset),
    .enc_data1(enc[0]), .enc_data2(enc[1]), .enc_data3(enc[2]), .enc_data4(enc[3]),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wen(reg_wen),
    .reg_raddr_chan(reg_raddr_chan), .reg_lim_data(reg_lim_data),
    .lim_fault(lim_fault), .amp_disable_req(amp_disable_req)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_fv();
    return {m_flt[3], m_flt[2], m_flt[1], m_flt[0]};
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 4; c++) begin
      m_lo[c] = 24'h000000; m_hi[c] = 24'hFFFFFF;
      m_en[c] = 0; m_oe[c] = 0; m_act[c] = 0; m_flt[c] = 0; m_run[c] = 0;
    end
    m_amp = 0;
  endtask

  // one clock: the model counts consecutive violating cycles while armed; a run of P latches the fault
  task automatic step();
    bit nflt [4], nact [4];
    int nrun [4];
    bit namp, v, sel;
    namp = m_flt[0] | m_flt[1] | m_flt[2] | m_flt[3];
    for (int c = 0; c < 4; c++) begin
      v = enc[c][23:0] < m_lo[c] || enc[c][23:0] > m_hi[c] || (m_oe[c] && enc[c][24]);
      sel = reg_wen && reg_waddr[15:12] == AM && reg_waddr[7:4] == 4'(c + 1);
      nflt[c] = m_flt[c]; nact[c] = m_act[c]; nrun[c] = m_run[c];
      if (m_flt[c]) begin
        if (sel && reg_waddr[3:0] == 4'hF && reg_wdata[31]) begin
          nflt[c] = 0; nrun[c] = 0; nact[c] = reg_wdata[0];
        end
      end else if (!m_act[c]) begin
        nrun[c] = 0; nact[c] = m_en[c];
      end else if (!m_en[c]) begin
        nrun[c] = 0; nact[c] = 0;
      end else if (v) begin
        nrun[c] = m_run[c] + 1;
        if (nrun[c] >= P) nflt[c] = 1;
      end else nrun[c] = 0;
      if (sel && reg_waddr[3:0] == 4'hD) m_lo[c] = reg_wdata[23:0];
      if (sel && reg_waddr[3:0] == 4'hE) m_hi[c] = reg_wdata[23:0];
      if (sel && reg_waddr[3:0] == 4'hF) begin
        m_en[c] = reg_wdata[0]; m_oe[c] = reg_wdata[1];
      end
    end
    @(posedge sysclk);
    #1;
    for (int c = 0; c < 4; c++) begin
      m_flt[c] = nflt[c]; m_act[c] = nact[c]; m_run[c] = nrun[c];
    end
    m_amp = namp;
    chk("lim_fault", 32'(lim_fault), 32'(m_fv()));
    chk("amp_disable_req", 32'(amp_disable_req), 32'(m_amp));
  endtask

  function automatic logic [31:0] rb_exp(logic [3:0] rc);
    int i;
    logic [1:0] st;
    if (rc[2:0] == 3'd0 || rc[2:0] > 3'd4) return 32'h0;
    i = int'(rc[2:0]) - 1;
    st = m_flt[i] ? 2'd3 : !m_act[i] ? 2'd0 : m_run[i] > 0 ? 2'd2 : 2'd1;
    return {st, m_oe[i], m_en[i], 3'b000, m_flt[i], rc[3] ? m_hi[i] : m_lo[i]};
  endfunction

  task automatic rb(logic [3:0] rc);
    reg_raddr_chan = rc;
    #1;
    chk("readback", reg_lim_data, rb_exp(rc));
  endtask

  task automatic wr(int ch, logic [3:0] off, logic [31:0] d);
    reg_wen = 1'b1;
    reg_waddr = {AM, 4'($urandom_range(0, 15)), 4'(ch), off};
    reg_wdata = d;
    step();
    reg_wen = 1'b0;
  endtask

  task automatic run_until(int b, int lim, output int n);
    n = 0;
    while (!lim_fault[b] && n < lim) begin
      step();
      n++;
    end
  endtask

  task automatic setup();
    for (int c = 1; c <= 4; c++) begin
      wr(c, 4'hD, 32'h007FF000);
      wr(c, 4'hE, 32'h00801000);
      wr(c, 4'hF, 32'h00000001);
    end
  endtask

  initial begin
    int n, ch;
    logic [3:0] off, rc;
    logic [31:0] d;
    for (int c = 0; c < 4; c++) enc[c] = 25'h0800000;
    m_reset();
    repeat (3) @(posedge sysclk);
    #1;
    chk("reset_fault", 32'(lim_fault), 32'h0);
    chk("reset_amp", 32'(amp_disable_req), 32'h0);
    rb(4'h9);
    rb(4'h1);
    reset = 1'b1;
    setup();
    repeat (1000) step();
    chk("quiet_faults", 32'(lim_fault), 32'h0);
    rb(4'h2);
    // ch2 above hi: fault after exactly P cycles, amp one cycle later
    enc[1] = 25'h0801001;
    run_until(1, 40, n);
    chk("ch2_latency", n, P);
    chk("ch2_only", 32'(lim_fault), 32'h2);
    step();
    chk("ch2_amp", 32'(amp_disable_req), 32'h1);
    // ch3 glitches one cycle short of the persistence window
    repeat (20) begin
      enc[2] = 25'h0801001;
      repeat (P - 1) step();
      enc[2] = 25'h0800000;
      step();
    end
    chk("ch3_glitch", 32'(lim_fault[2]), 32'h0);
    // ch1 fault, clear with position back in range
    enc[0] = 25'h07FEFFF;
    run_until(0, 40, n);
    chk("ch1_latency", n, P);
    enc[0] = 25'h0800000;
    step();
    wr(1, 4'hF, 32'h80000001);
    chk("ch1_cleared", 32'(lim_fault[0]), 32'h0);
    rb(4'h1);
    // clear while still violating re-faults after a full window
    enc[0] = 25'h07FEFFF;
    run_until(0, 40, n);
    wr(1, 4'hF, 32'h80000001);
    chk("ch1_clear_out", 32'(lim_fault[0]), 32'h0);
    run_until(0, 40, n);
    chk("ch1_refault", n, P);
    // ch4 overflow bit only matters with ovf_en
    enc[3] = 25'h1800000;
    repeat (30) step();
    chk("ch4_no_ovf", 32'(lim_fault[3]), 32'h0);
    wr(4, 4'hF, 32'h00000003);
    run_until(3, 40, n);
    chk("ch4_ovf", n, P);
    // ch1 into PENDING with counter 10, then asynchronous reset
    enc[0] = 25'h0800000;
    wr(1, 4'hF, 32'h80000001);
    enc[0] = 25'h07FEFFF;
    repeat (10) step();
    rb(4'h1);
    #1;
    reset = 1'b0;
    #1;
    m_reset();
    chk("async_fault", 32'(lim_fault), 32'h0);
    chk("async_amp", 32'(amp_disable_req), 32'h0);
    rb(4'h1);
    rb(4'h9);
    reset = 1'b1;
    step();
    rb(4'h1);
    rb(4'hC);
    for (int c = 0; c < 4; c++) enc[c] = 25'h0800000;
    setup();
    repeat (3000) begin
      ch = $urandom_range(0, 3);
      enc[ch] = {1'($urandom_range(0, 7) == 0), 24'(24'h7FE800 + $urandom_range(0, 24'h3000))};
      if ($urandom_range(0, 15) == 0) begin
        ch = $urandom_range(0, 5);
        off = 4'(4'hD + $urandom_range(0, 2));
        d = off == 4'hF ? {1'($urandom_range(0, 1)), 29'h0, 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 3) != 0)}
                        : 32'(24'h7FF000 + $urandom_range(0, 24'h2000));
        wr(ch, off, d);
      end else step();
      rc = 4'($urandom_range(0, 15));
      rb(rc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/enc_limit_monitor.md
Name: enc_limit_monitor

Overview:
- Per-channel encoder position safety monitor. Sits directly downstream of the encoder controller and consumes its four 25-bit position words (enc_data1..4: overflow bit 24, count [23:0]).
- Compares each channel against programmable lower/upper limits and requires the violation to persist before acting.
- Latches a per-channel fault and drives an amplifier-disable request to the power-control logic.
- Limits, enables and fault clear are programmed over the same register write bus used for encoder preload.

Parameters:
- NUM_CH, 4, number of monitored channels. Fixed at 4 to match enc_data1..4.
- PERSIST, 16, consecutive sysclk cycles a violation must hold before faulting. Range 1..255.
- CNT_W, 8, width of the persistence counter.

Ports:
- sysclk  in  1  global clock
- reset  in  1  reset, asynchronous, active-low
- enc_data1..enc_data4  in  25 each  position from encoder controller; bit 24 = overflow
- reg_waddr  in  16  register write address
- reg_wdata  in  32  register write data
- reg_wen  in  1  write strobe, single-cycle
- reg_raddr_chan  in  4  read channel select (1..4)
- reg_lim_data  out  32  {status[7:0], limit readback[23:0]}, see Behaviour
- lim_fault  out  4  latched fault per channel, bit i-1 = channel i
- amp_disable_req  out  1  OR of lim_fault

Behaviour:
- Reset (reset=0, async):
  - lo_lim = 24'h000000, hi_lim = 24'hFFFFFF.
  - enable = 0, ovf_en = 0, counters = 0, state = IDLE.
  - lim_fault = 0, amp_disable_req = 0.
- Register writes are decoded when reg_wen && reg_waddr[15:12]==`ADDR_MAIN. Channel = reg_waddr[7:4]; channel 0 or >4 is ignored. Offsets (reg_waddr[3:0]), defined as new constants in Constants.v:
  - `OFF_LIM_LO = 4'hD: lo_lim <= wdata[23:0].
  - `OFF_LIM_HI = 4'hE: hi_lim <= wdata[23:0].
  - `OFF_LIM_CTRL = 4'hF: enable <= wdata[0]; ovf_en <= wdata[1]; wdata[31] = fault clear.
- Violation (combinational, per channel):
  - viol = (count < lo_lim) || (count > hi_lim) || (ovf_en && bit24).
  - Compare is unsigned 24-bit.
  - If lo_lim > hi_lim, every position violates. This is intended as a test hook.
- Per-channel FSM, registered on sysclk:
  - IDLE: enable=0; counter=0. Moves to ARMED when enable=1.
  - ARMED: viol=1 -> PENDING with counter=1 (when PERSIST=1, go straight to FAULT instead).
  - PENDING: viol=1 -> counter+1; when counter+1==PERSIST -> FAULT. viol=0 -> ARMED with counter=0 (glitch rejected).
  - FAULT: lim_fault[i]=1. Only a CTRL write with wdata[31]=1 exits:
    - exits to ARMED if the new enable=1, otherwise to IDLE;
    - counter cleared;
    - if viol is still present, the channel re-enters PENDING on the next cycle, so re-faulting takes PERSIST cycles again.
  - enable written 0 from ARMED or PENDING -> IDLE next cycle. From FAULT the fault stays latched (enable alone does not clear it).
- Latency:
  - Violation onset to lim_fault high = PERSIST cycles (violation sampled at cycle 0; flag registered at the edge ending cycle PERSIST-1).
  - amp_disable_req is registered, one cycle after lim_fault.
- Simultaneous events:
  - A clear and a violation in the same cycle: the clear wins; the violation is re-evaluated next cycle.
  - A limit write takes effect on the comparison the following cycle.
- Counter saturates at PERSIST and never wraps.
- Readback: reg_lim_data = {state[1:0], ovf_en, enable, 3'b0, lim_fault[ch], hi_lim or lo_lim}.
  - Selector: reg_raddr_chan[3] picks hi (1) / lo (0). Channel = {1'b0, reg_raddr_chan[2:0]}.
  - Combinational. Out-of-range channel returns 0.

Test Plan:
- Reset release; all channels enabled with lo=24'h7FF000, hi=24'h801000, enc=24'h800000 -> no fault for 1000 cycles; lim_fault=4'b0000.
- Ch2 enc steps to 24'h801001 and holds:
  - lim_fault[1] rises exactly 16 cycles later;
  - amp_disable_req rises 1 cycle after that;
  - the other channels stay 0.
- Ch3 violation pulses of 15 cycles separated by 1 in-range cycle, repeated 20 times -> no fault.
- Ch1 faulted, enc returned in range, CTRL write wdata=32'h8000_0001 -> lim_fault[0]=0 next cycle, state ARMED.
  - Repeat with enc still out of range -> fault reasserts 16 cycles after the clear.
- Ch4 enc bit24=1, count in range: ovf_en=0 -> no fault; ovf_en=1 -> fault after 16 cycles.
- reset asserted mid-PENDING (counter=10) -> all outputs 0 immediately (asynchronous), limits restored to defaults.
  - After release, enable reads 0 and the channel is in IDLE.
